// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Round-robin tie-breaking is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {CORE, EXT} owner_t;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between core and external loader.
// DMEM_ARB_RR_EN selects round-robin ties; otherwise core always wins.
module arb_pick (
  input  logic c_req,
  input  logic e_req,
`ifdef DMEM_ARB_RR_EN
  input  logic last_ext,
`endif
  output logic any_req,
  output logic pick_ext
);
  assign any_req = c_req | e_req;
`ifdef DMEM_ARB_RR_EN
  // a tie goes to whichever port was not served last
  assign pick_ext = e_req & (~c_req | ~last_ext);
`else
  assign pick_ext = e_req & ~c_req;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE/ACCESS/RESP, one transaction per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin ties (default: fixed core priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t state, state_nxt;
  owner_t owner_q, win;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q, e_rdata_q;
  logic [DATA_W-1:0] resp_data;
  logic              any_req, pick_ext, grant;

`ifdef DMEM_ARB_RR_EN
  owner_t last_owner;

  always_ff @(posedge clk or posedge reset)
    if (reset)      last_owner <= EXT;
    else if (grant) last_owner <= win;
`endif

  arb_pick u_pick (
    .c_req    (c_req),
    .e_req    (e_req),
`ifdef DMEM_ARB_RR_EN
    .last_ext (last_owner == EXT),
`endif
    .any_req  (any_req),
    .pick_ext (pick_ext)
  );

  assign win   = pick_ext ? EXT : CORE;
  // reset forces IDLE asynchronously, so grant must also be masked by reset
  assign grant = (state == IDLE) & any_req & ~reset;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner_q <= CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= win;
      we_q    <= pick_ext ? e_we    : c_we;
      addr_q  <= pick_ext ? e_addr  : c_addr;
      wdata_q <= pick_ext ? e_wdata : c_wdata;
    end

  assign resp_data = we_q ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      c_rdata_q <= '0;
      e_rdata_q <= '0;
    end else if (state == RESP) begin
      if (owner_q == CORE) c_rdata_q <= resp_data;
      else                 e_rdata_q <= resp_data;
    end

  // read data arrives during RESP; bypass it so it is visible with rvalid
  assign c_rdata = (state == RESP && owner_q == CORE) ? resp_data : c_rdata_q;
  assign e_rdata = (state == RESP && owner_q == EXT)  ? resp_data : e_rdata_q;

  always_comb begin
    state_nxt = state;
    c_gnt     = 1'b0;
    e_gnt     = 1'b0;
    c_rvalid  = 1'b0;
    e_rvalid  = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        c_gnt = grant & ~pick_ext;
        e_gnt = grant &  pick_ext;
        if (grant) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wr    = we_q;
        mem_rd    = ~we_q;
        state_nxt = RESP;
      end
      RESP: begin
        c_rvalid  = (owner_q == CORE);
        e_rvalid  = (owner_q == EXT);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter ADDR_W, default 9, data-memory word address width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 Ports c_req, c_we: input, 1 each; core request and write-enable. c_addr: input, ADDR_W. c_wdata: input, DATA_W.
REQ-006 Outputs c_gnt, c_rvalid: 1 each; core grant and completion. c_rdata: DATA_W.
REQ-007 External loader port e_req, e_we, e_addr, e_wdata, e_gnt, e_rvalid, e_rdata SHALL mirror REQ-005/006.
REQ-008 Outputs mem_wr, mem_rd: 1 each; mem_addr: ADDR_W; mem_wdata: DATA_W. Input mem_rdata: DATA_W, valid one cycle after mem_rd (synchronous read).
REQ-009 Output busy, 1: high whenever state is not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, ACCESS and RESP; each transaction takes exactly 3 cycles; throughput is one transaction per 3 cycles.
REQ-011 IDLE: if any req is high, pick a winner, assert its gnt combinationally that cycle, latch its we/addr/wdata and owner, then go to ACCESS; otherwise stay in IDLE.
REQ-012 A requester SHALL hold req and its fields stable until gnt; req dropped before gnt has no effect.
REQ-013 ACCESS: drive mem_addr/mem_wdata from latched fields; assert mem_wr if latched we, else mem_rd; exactly one strobe for one cycle; go to RESP.
REQ-014 RESP: pulse owner's rvalid for one cycle; owner's rdata = mem_rdata for reads, 0 for writes; the other port's rvalid stays 0; go to IDLE.
REQ-015 rdata of each port SHALL be registered and hold its last value until the next completion to that port.
REQ-016 gnt SHALL never be asserted outside IDLE; at most one gnt is high per cycle.
REQ-017 Requests arriving in ACCESS/RESP wait; they are not lost if req is held.
REQ-018 Simultaneous c_req and e_req SHALL be resolved per REQ-022/023.
REQ-019 mem_* outputs SHALL be 0 in IDLE and RESP.

Reset
REQ-020 While reset is high: state = IDLE; all gnt, rvalid, mem_wr, mem_rd, busy = 0; rdata registers = 0; latched fields = 0; last_owner = EXT.
REQ-021 Reset asserted mid-transaction SHALL abort it: no rvalid is issued and no memory strobe follows release.

Configuration
REQ-022 Without macro DMEM_ARB_RR_EN: fixed priority; core wins every tie.
REQ-023 With DMEM_ARB_RR_EN defined: round-robin; a tie goes to the port that is not last_owner; last_owner updates on each grant. A sole requester always wins.

Structure
REQ-024 Package dmem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), the owner enum (CORE, EXT) and default width constants.
REQ-025 One sub-module, arb_pick, SHALL contain the combinational winner selection, including the DMEM_ARB_RR_EN variant; the FSM and registers remain in dmem_arbiter.

Verification
REQ-026 Core read, addr 0x010, mem_rdata 0xDEADBEEF -> c_gnt at T0, mem_rd at T1 with mem_addr 0x010, c_rvalid at T2 with c_rdata 0xDEADBEEF.
REQ-027 Ext write, addr 0x1FF, data 0x12345678 -> e_gnt at T0, mem_wr at T1 with that addr/data, e_rvalid at T2 with e_rdata 0, c_rvalid 0.
REQ-028 Both ports request at T0 and hold -> fixed priority: core served T0-T2, ext granted T3; with RR_EN, two back-to-back ties grant core then ext.
REQ-029 Reset pulse during ACCESS of a read -> no rvalid, outputs 0, next request is granted normally after release.
REQ-030 Core request raised during RESP -> no c_gnt until the next IDLE cycle; c_gnt never coincides with busy = 1.
